// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Function : Multicycle MIPS control unit (Moore FSM, ALU decoder, PC enable).
// Revision : 1.0
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Unknown opcodes fall back to FETCH from DECODE, retiring as a nop.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_aluop   = 2'b00;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Unlisted funct codes decode to add so the ALU never sees an X.
    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen  = w_pcwrite | (w_branch & zero);
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Function : Directed self-checking bench for mc_controller.
// Revision : 1.0
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic [14:0] w_ctrl;

    int vecs = 0;
    int errs = 0;

    // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
    localparam logic [14:0] c_FETCH = 15'b1010_0000_01_00_010;
    localparam logic [14:0] c_DEC   = 15'b0000_0000_11_00_010;
    localparam logic [14:0] c_MADR  = 15'b0000_1000_10_00_010;
    localparam logic [14:0] c_MRD   = 15'b0000_0100_00_00_010;
    localparam logic [14:0] c_MWB   = 15'b0001_0010_00_00_010;
    localparam logic [14:0] c_MWR   = 15'b0100_0100_00_00_010;
    localparam logic [14:0] c_EXEC  = 15'b0000_1000_00_00_000;
    localparam logic [14:0] c_AWB   = 15'b0001_0001_00_00_010;
    localparam logic [14:0] c_BR0   = 15'b0000_1000_00_01_110;
    localparam logic [14:0] c_BR1   = 15'b1000_1000_00_01_110;
    localparam logic [14:0] c_AIWB  = 15'b0001_0000_00_00_010;
    localparam logic [14:0] c_JMP   = 15'b1000_0000_00_10_010;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    assign w_ctrl = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
                     regdst, alusrcb, pcsrc, alucontrol};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Check state and control word now, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] ctl);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".ctrl"}, {17'd0, w_ctrl}, {17'd0, ctl});
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  fn [6];
        logic [2:0]  ac [6];
        fn[0] = 6'b100000; ac[0] = 3'b010;
        fn[1] = 6'b100010; ac[1] = 3'b110;
        fn[2] = 6'b100100; ac[2] = 3'b000;
        fn[3] = 6'b100101; ac[3] = 3'b001;
        fn[4] = 6'b101010; ac[4] = 3'b111;
        fn[5] = 6'b000000; ac[5] = 3'b010;

        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;

        @(negedge clk);
        cyc("rst0", 4'd0, c_FETCH);
        cyc("rst1", 4'd0, c_FETCH);
        reset = 1'b0;

        // lw
        cyc("lw.f", 4'd0, c_FETCH);
        cyc("lw.d", 4'd1, c_DEC);
        cyc("lw.a", 4'd2, c_MADR);
        cyc("lw.r", 4'd3, c_MRD);
        cyc("lw.w", 4'd4, c_MWB);

        // R-type across all functs
        op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = fn[i];
            cyc("r.f", 4'd0, c_FETCH);
            cyc("r.d", 4'd1, c_DEC);
            cyc($sformatf("r.e%0d", i), 4'd6, c_EXEC | {12'd0, ac[i]});
            cyc("r.w", 4'd7, c_AWB);
        end

        // beq taken then not taken
        op = 6'b000100;
        funct = 6'b100000;
        zero = 1'b1;
        cyc("beq1.f", 4'd0, c_FETCH);
        cyc("beq1.d", 4'd1, c_DEC);
        cyc("beq1.b", 4'd8, c_BR1);
        zero = 1'b0;
        cyc("beq0.f", 4'd0, c_FETCH);
        cyc("beq0.d", 4'd1, c_DEC);
        cyc("beq0.b", 4'd8, c_BR0);

        // sw
        op = 6'b101011;
        cyc("sw.f", 4'd0, c_FETCH);
        cyc("sw.d", 4'd1, c_DEC);
        cyc("sw.a", 4'd2, c_MADR);
        cyc("sw.m", 4'd5, c_MWR);

        // addi
        op = 6'b001000;
        cyc("addi.f", 4'd0, c_FETCH);
        cyc("addi.d", 4'd1, c_DEC);
        cyc("addi.e", 4'd9, c_MADR);
        cyc("addi.w", 4'd10, c_AIWB);

        // j
        op = 6'b000010;
        cyc("j.f", 4'd0, c_FETCH);
        cyc("j.d", 4'd1, c_DEC);
        cyc("j.j", 4'd11, c_JMP);

        // unknown opcode behaves as nop
        op = 6'b111111;
        cyc("nop.f", 4'd0, c_FETCH);
        cyc("nop.d", 4'd1, c_DEC);

        // async reset while in ALUWB
        op = 6'b000000;
        funct = 6'b100000;
        cyc("ar.f", 4'd0, c_FETCH);
        cyc("ar.d", 4'd1, c_DEC);
        cyc("ar.e", 4'd6, c_EXEC | 15'd2);
        chk("ar.pre_rw", {31'd0, regwrite}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar.state", {28'd0, state}, 32'd0);
        chk("ar.rw", {31'd0, regwrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc("ar.post", 4'd0, c_FETCH);
        cyc("ar.dec", 4'd1, c_DEC);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
